// File: rtl/mem_access_unit.sv
// Data-memory access sequencer: scalar load/store and 64-bit vector store over a gnt/rvalid bus.
// Latency: store 1 cycle after gnt, load 1 cycle after rvalid; results registered, then one DONE cycle.
// Backpressure: StallMem holds the pipeline until DONE; a missing gnt/rvalid aborts after TIMEOUT_CYC cycles.
module mem_access_unit #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] AluOutM,
  input  logic [31:0] StoreDataM,
  input  logic [3:0]  MemWriteM,
  input  logic        MemToRegM,
  input  logic [2:0]  RegWriteM,
  input  logic        MemWriteVecM,
  input  logic [63:0] VecRegWriteData,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        StallMem,
  output logic [31:0] LoadDataW,
  output logic        LoadValid,
  output logic        BusErr
);

  // Counter only has to reach TIMEOUT_CYC-1 (the last waiting cycle before abort).
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_VEC2, S_DONE} state_t;
  typedef enum logic [1:0] {K_LD, K_ST, K_VEC} kind_t;

  state_t        state_q, state_d;
  kind_t         kind_q, kind_d;
  logic [1:0]    off_q, off_d;
  logic [2:0]    ltype_q, ltype_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [3:0]    bus_be_q, bus_be_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic [31:0]   load_data_q, load_data_d;
  logic          load_valid_q, load_valid_d;
  logic          bus_err_q, bus_err_d;

  logic          access;
  logic          drop_bus;
  logic          abort;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_fmt;

  assign access   = MemWriteVecM | (MemWriteM != 4'b0000) | MemToRegM;
  assign StallMem = access & (state_q != S_DONE);

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_be    = bus_be_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign LoadDataW = load_data_q;
  assign LoadValid = load_valid_q;
  assign BusErr    = bus_err_q;

  // Extract and extend the addressed byte/half from the returned word.
  always_comb begin
    ld_byte = 8'(bus_rdata >> {off_q, 3'b000});
    ld_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (ltype_q)
      3'd1:    ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'd2:    ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_fmt = {24'h0, ld_byte};
      3'd5:    ld_fmt = {16'h0, ld_half};
      default: ld_fmt = bus_rdata;
    endcase
  end

  // Next-state and registered-output logic for the access sequencer.
  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    off_d        = off_q;
    ltype_d      = ltype_q;
    cnt_d        = cnt_q + CW'(1);
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_be_d     = bus_be_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    bus_err_d    = 1'b0;
    drop_bus     = 1'b0;
    abort        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (access) begin
          state_d    = S_REQ;
          off_d      = AluOutM[1:0];
          ltype_d    = RegWriteM;
          bus_req_d  = 1'b1;
          bus_addr_d = {AluOutM[31:2], 2'b00};
          if (MemWriteVecM) begin
            kind_d      = K_VEC;
            bus_we_d    = 1'b1;
            bus_be_d    = 4'hF;
            bus_wdata_d = VecRegWriteData[31:0];
          end else if (MemWriteM != 4'b0000) begin
            // A store that also flags a load is performed as the store alone.
            kind_d      = K_ST;
            bus_we_d    = 1'b1;
            bus_be_d    = MemWriteM << AluOutM[1:0];
            bus_wdata_d = StoreDataM << {AluOutM[1:0], 3'b000};
          end else begin
            kind_d      = K_LD;
            bus_we_d    = 1'b0;
            bus_be_d    = 4'hF;
            bus_wdata_d = 32'h0;
          end
        end
      end
      S_REQ: begin
        if (bus_gnt) begin
          cnt_d = '0;
          if (kind_q == K_VEC) begin
            state_d     = S_VEC2;
            bus_addr_d  = bus_addr_q + 32'd4;
            bus_wdata_d = VecRegWriteData[63:32];
          end else begin
            drop_bus = 1'b1;
            state_d  = (kind_q == K_ST) ? S_DONE : S_WAIT;
          end
        end else if (cnt_q == CNT_LAST) begin
          abort = 1'b1;
        end
      end
      S_VEC2: begin
        if (bus_gnt) begin
          drop_bus = 1'b1;
          state_d  = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          abort = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus_rvalid) begin
          load_data_d  = ld_fmt;
          load_valid_d = 1'b1;
          state_d      = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          abort = 1'b1;
        end
      end
      S_DONE: begin
        // One cycle of release so the pipeline advances; never starts a new access here.
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      drop_bus    = 1'b1;
      bus_err_d   = 1'b1;
      load_data_d = 32'h0;
      state_d     = S_DONE;
    end

    if (drop_bus) begin
      bus_req_d   = 1'b0;
      bus_we_d    = 1'b0;
      bus_be_d    = 4'h0;
      bus_addr_d  = 32'h0;
      bus_wdata_d = 32'h0;
    end
  end

  // All sequencer state; reset clears everything immediately, even mid-transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      kind_q       <= K_LD;
      off_q        <= 2'b00;
      ltype_q      <= 3'd0;
      cnt_q        <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_be_q     <= 4'h0;
      bus_addr_q   <= 32'h0;
      bus_wdata_q  <= 32'h0;
      load_data_q  <= 32'h0;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      off_q        <= off_d;
      ltype_q      <= ltype_d;
      cnt_q        <= cnt_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_be_q     <= bus_be_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      bus_err_q    <= bus_err_d;
    end
  end

endmodule
